mbus_rbtr: RTL and testbench

MBUS_RBTR -- requirements
Module: mbus_rbtr

---
 rtl/mbus_pkg.sv | 26 ++
 rtl/mbus_lane.sv | 132 +++++++++++++
 rtl/mbus_rbtr.sv | 49 ++++
 tb/tb_mbus_rbtr.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mbus_pkg.sv
// Purpose : shared types for the multi-bus packet arbiter (FSM states, arbitration modes, ID width).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mbus_pkg;

  // Destination ID occupies the top ID_W bits of every packet.
  localparam int ID_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Round-robin search order: offset 0 is the device right after the last
  // grantee, offset n-1 is the last grantee itself (lowest priority).
  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + 1 + off) % n;
  endfunction

endpackage

// File: rtl/mbus_lane.sv
// Purpose : one bus - arbiter, IDLE->GRANT->DELIVER FSM and destination decoder.
// Latency : pndng seen at edge N -> pop in cycle N+1 -> push in cycle N+2; one packet per 3 cycles.
// Backpressure: none; devices are always ready to accept a push, unknown destinations are dropped.
// Ports   : pndng/d_pop from device FIFOs, pop/push/d_push to devices,
//           busy (not IDLE), err_drop (drop pulse), drop_cnt (saturating drop count).
module mbus_lane
  import mbus_pkg::*;
#(
  parameter int              DRVRS     = 5,
  parameter int              PCKG_SZ   = 16,
  parameter logic [ID_W-1:0] BROADCAST = 8'h8F,
  parameter int              ARB_MODE  = 1,
  parameter int              CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   d_pop,
  output logic [DRVRS-1:0]                pop,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   d_push,
  output logic                            busy,
  output logic                            err_drop,
  output logic [CNT_W-1:0]                drop_cnt
);

  localparam int        GW   = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam arb_mode_e MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

  state_e             state_q, state_d;
  // gnt_q is loaded when leaving IDLE, so it is both the current source
  // (GRANT/DELIVER) and the round-robin "last grant" for the next search.
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [PCKG_SZ-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [GW-1:0]      sel;
  logic               found;
  logic [ID_W-1:0]    dest;
  logic [DRVRS-1:0]   tgt;
  logic               drop;

  // Arbiter: first pending device in priority order.
  always_comb begin
    sel   = gnt_q;
    found = 1'b0;
    for (int i = 0; i < DRVRS; i++) begin
      if (MODE == ARB_RR) begin
        if (!found && pndng[rr_idx(int'(gnt_q), i, DRVRS)]) begin
          sel   = GW'(rr_idx(int'(gnt_q), i, DRVRS));
          found = 1'b1;
        end
      end else begin
        if (!found && pndng[i]) begin
          sel   = GW'(i);
          found = 1'b1;
        end
      end
    end
  end

  // Decoder: unicast IDs take precedence over the broadcast ID.
  always_comb begin
    dest = pkt_q[PCKG_SZ-1 -: ID_W];
    tgt  = '0;
    for (int i = 0; i < DRVRS; i++) begin
      tgt[i] = (int'(dest) == i) ||
               ((dest == BROADCAST) && (i != int'(gnt_q)));
    end
    drop = (int'(dest) >= DRVRS) && (dest != BROADCAST);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|pndng) begin
          state_d = ST_GRANT;
          gnt_d   = sel;
        end
      end
      ST_GRANT: begin
        pkt_d   = d_pop[gnt_q];
        state_d = ST_DELIVER;
      end
      ST_DELIVER: begin
        state_d = ST_IDLE;
        if (drop && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= GW'(DRVRS - 1);
      pkt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Push and drop pulses are masked while reset is high so a packet caught
  // in DELIVER by a reset is neither delivered nor reported.
  always_comb begin
    pop      = '0;
    push     = '0;
    err_drop = 1'b0;
    for (int i = 0; i < DRVRS; i++) begin
      pop[i]    = (state_q == ST_GRANT) && (int'(gnt_q) == i);
      d_push[i] = pkt_q;
    end
    if ((state_q == ST_DELIVER) && !reset) begin
      push     = tgt;
      err_drop = drop;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign drop_cnt = cnt_q;

endmodule

// File: rtl/mbus_rbtr.sv
// Purpose : multi-bus packet arbiter; one independent mbus_lane per bus.
// Latency : pop one cycle after pndng is sampled, push one cycle after pop.
// Backpressure: none; each bus serves one packet per 3 cycles, bad destinations are dropped and counted.
// Ports   : clk, reset (sync, active-high); per bus b: pndng/D_pop in, pop/push/D_push out,
//           busy, err_drop, drop_cnt.
module mbus_rbtr
  import mbus_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 5,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'h8F,
  parameter int              ARB_MODE  = 1,
  parameter int              CNT_W     = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [bits-1:0][drvrs-1:0]             pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]             pop,
  output logic [bits-1:0][drvrs-1:0]             push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push,
  output logic [bits-1:0]                        busy,
  output logic [bits-1:0]                        err_drop,
  output logic [bits-1:0][CNT_W-1:0]             drop_cnt
);

  for (genvar b = 0; b < bits; b++) begin : g_lane
    mbus_lane #(
      .DRVRS     (drvrs),
      .PCKG_SZ   (pckg_sz),
      .BROADCAST (broadcast),
      .ARB_MODE  (ARB_MODE),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .pndng    (pndng[b]),
      .d_pop    (D_pop[b]),
      .pop      (pop[b]),
      .push     (push[b]),
      .d_push   (D_push[b]),
      .busy     (busy[b]),
      .err_drop (err_drop[b]),
      .drop_cnt (drop_cnt[b])
    );
  end

endmodule

// File: tb/tb_mbus_rbtr.sv
// Purpose : directed self-checking bench for mbus_rbtr (two instances: 2-bus round-robin, 1-bus fixed priority).
// Latency : checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_mbus_rbtr;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 buses, round-robin, small counter so saturation is reachable.
  logic [1:0][4:0]        pndng_a, pop_a, push_a;
  logic [1:0][4:0][15:0]  dpop_a, dpush_a;
  logic [1:0]             busy_a, err_a;
  logic [1:0][3:0]        cnt_a;

  // Instance B: 1 bus, fixed priority.
  logic [0:0][4:0]        pndng_b, pop_b, push_b;
  logic [0:0][4:0][15:0]  dpop_b, dpush_b;
  logic [0:0]             busy_b, err_b;
  logic [0:0][15:0]       cnt_b;

  mbus_rbtr #(.bits(2), .drvrs(5), .pckg_sz(16), .broadcast(8'h8F), .ARB_MODE(1), .CNT_W(4)) u_rr (
    .clk(clk), .reset(reset), .pndng(pndng_a), .D_pop(dpop_a), .pop(pop_a), .push(push_a),
    .D_push(dpush_a), .busy(busy_a), .err_drop(err_a), .drop_cnt(cnt_a));

  mbus_rbtr #(.bits(1), .drvrs(5), .pckg_sz(16), .broadcast(8'h8F), .ARB_MODE(0), .CNT_W(16)) u_fp (
    .clk(clk), .reset(reset), .pndng(pndng_b), .D_pop(dpop_b), .pop(pop_b), .push(push_b),
    .D_push(dpush_b), .busy(busy_b), .err_drop(err_b), .drop_cnt(cnt_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int rr_exp [5] = '{0, 3, 4, 0, 3};

  initial begin
    pndng_a = '0; dpop_a = '0;
    pndng_b = '0; dpop_b = '0;

    // Reset state
    reset = 1'b1;
    tick();
    chk("rst_pop_a",   pop_a,   0);
    chk("rst_push_a",  push_a,  0);
    chk("rst_busy_a",  busy_a,  0);
    chk("rst_err_a",   err_a,   0);
    chk("rst_cnt_a",   cnt_a,   0);
    chk("rst_dpush_a", dpush_a[0][0], 0);
    chk("rst_busy_b",  busy_b,  0);
    chk("rst_cnt_b",   cnt_b,   0);
    tick();
    reset = 1'b0;

    // Single unicast: source 2 -> device 3; pndng drops during GRANT
    pndng_a[0][2] = 1'b1; dpop_a[0][2] = 16'h0355;
    tick();
    chk("uni_pop",  pop_a[0],  5'b00100);
    chk("uni_busy", busy_a[0], 1);
    chk("uni_push_in_grant", push_a[0], 0);
    pndng_a[0][2] = 1'b0;
    tick();
    chk("uni_push",  push_a[0],  5'b01000);
    chk("uni_dpush", dpush_a[0][3], 16'h0355);
    chk("uni_pop_in_deliver", pop_a[0], 0);
    chk("uni_err",   err_a[0], 0);
    tick();
    chk("uni_push_after", push_a[0], 0);
    chk("uni_idle", busy_a[0], 0);

    // Broadcast from source 1 (round-robin search starts at 3 and wraps to 1)
    pndng_a[0][1] = 1'b1; dpop_a[0][1] = 16'h8FAA;
    tick();
    chk("bc_pop", pop_a[0], 5'b00010);
    pndng_a[0][1] = 1'b0;
    tick();
    chk("bc_push",  push_a[0], 5'b11101);
    chk("bc_dpush", dpush_a[0][4], 16'h8FAA);
    tick();
    chk("bc_idle", busy_a[0], 0);

    // Invalid destination 0x07
    pndng_a[0][0] = 1'b1; dpop_a[0][0] = 16'h07C1;
    tick();
    chk("bad_pop", pop_a[0], 5'b00001);
    pndng_a[0][0] = 1'b0;
    tick();
    chk("bad_push", push_a[0], 0);
    chk("bad_err",  err_a[0], 1);
    tick();
    chk("bad_err_off", err_a[0], 0);
    chk("bad_cnt",     cnt_a[0], 1);

    // Arbitration: devices 0,3,4 pending continuously on both instances
    do_reset();
    for (int k = 0; k < 5; k++) dpop_a[0][k] = 16'h0100;
    dpop_b[0] = '{default: 16'h0100};
    pndng_a[0] = 5'b11001;
    pndng_b[0] = 5'b11001;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr_grant", pop_a[0], 32'(1) << rr_exp[n]);
      if (n < 3) chk("fp_grant", pop_b[0], 5'b00001);
      tick();
      chk("rr_push", push_a[0], 5'b00010);
      tick();
    end
    pndng_a[0] = '0;
    pndng_b[0] = '0;
    tick();
    tick();

    // Saturating drop counter on bus 1 (CNT_W=4): 19 bad packets
    pndng_a[1][2] = 1'b1; dpop_a[1][2] = 16'h07C1;
    for (int n = 1; n <= 19; n++) begin
      tick();
      tick();
      tick();
      if (n == 14) chk("sat_cnt14", cnt_a[1], 4'hE);
    end
    pndng_a[1] = '0;
    chk("sat_cnt", cnt_a[1], 4'hF);
    chk("sat_other_bus", cnt_a[0], 0);
    tick();
    tick();
    chk("sat_hold", cnt_a[1], 4'hF);

    // Reset while in DELIVER
    pndng_a[0][1] = 1'b1; dpop_a[0][1] = 16'h0255;
    tick();
    chk("rd_pop", pop_a[0], 5'b00010);
    pndng_a[0][1] = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rd_push_masked", push_a[0], 0);
    tick();
    chk("rd_busy", busy_a[0], 0);
    chk("rd_push", push_a[0], 0);
    chk("rd_cnt",  cnt_a[0], 0);
    chk("rd_err",  err_a[0], 0);
    reset = 1'b0;
    // Next packet served normally; last grant was reset to 4
    pndng_a[0][3] = 1'b1; dpop_a[0][3] = 16'h0055;
    tick();
    chk("rd_next_pop", pop_a[0], 5'b01000);
    pndng_a[0][3] = 1'b0;
    tick();
    chk("rd_next_push",  push_a[0], 5'b00001);
    chk("rd_next_dpush", dpush_a[0][0], 16'h0055);
    tick();

    // Two buses, staggered by one cycle
    pndng_a[0][4] = 1'b1; dpop_a[0][4] = 16'h0155;
    tick();
    chk("dual_pop_e1",  pop_a,  {5'b00000, 5'b10000});
    chk("dual_push_e1", push_a, 0);
    pndng_a[0][4] = 1'b0;
    pndng_a[1][0] = 1'b1; dpop_a[1][0] = 16'h02AA;
    tick();
    chk("dual_pop_e2",  pop_a,  {5'b00001, 5'b00000});
    chk("dual_push_e2", push_a, {5'b00000, 5'b00010});
    pndng_a[1][0] = 1'b0;
    tick();
    chk("dual_pop_e3",  pop_a,  0);
    chk("dual_push_e3", push_a, {5'b00100, 5'b00000});
    chk("dual_dpush1",  dpush_a[1][2], 16'h02AA);
    chk("dual_busy_e3", busy_a, 2'b10);
    tick();
    chk("dual_idle", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
